// File: rtl/logic_reduce_pipe.sv
// Multi-lane bit reducer (AND/OR/XOR/NAND per beat) feeding a PIPE_STAGES-deep
// valid/ready pipeline with full backpressure and a saturating delivery counter.
module logic_reduce_pipe #(
  parameter int NO_OF_GATES  = 1,
  parameter int NO_OF_INPUTS = 4,
  parameter int PIPE_STAGES  = 1,
  parameter int CNT_W        = 16
) (
  input  logic                                 clock0,
  input  logic                                 reset0_n,
  input  logic [NO_OF_INPUTS*NO_OF_GATES-1:0]  in_data,
  input  logic [1:0]                           mode,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [NO_OF_GATES-1:0]               out1,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [CNT_W-1:0]                     out_count
);

  typedef enum logic [1:0] {
    MODE_AND  = 2'b00,
    MODE_OR   = 2'b01,
    MODE_XOR  = 2'b10,
    MODE_NAND = 2'b11
  } mode_e;

  localparam int LAST = PIPE_STAGES - 1;

  function automatic logic reduce_lane(input logic [NO_OF_INPUTS-1:0] bits, input mode_e m);
    logic r;
    r = 1'b0;
    unique case (m)
      MODE_AND:  r = &bits;
      MODE_OR:   r = |bits;
      MODE_XOR:  r = ^bits;
      MODE_NAND: r = ~&bits;
    endcase
    return r;
  endfunction

  // Operands of one lane are strided by NO_OF_GATES in the packed input.
  logic [NO_OF_GATES-1:0] reduced;

  for (genvar i = 0; i < NO_OF_GATES; i++) begin : g_lane
    logic [NO_OF_INPUTS-1:0] operands;
    for (genvar k = 0; k < NO_OF_INPUTS; k++) begin : g_op
      assign operands[k] = in_data[k*NO_OF_GATES + i];
    end
    assign reduced[i] = reduce_lane(operands, mode_e'(mode));
  end

  logic                   started;
  logic                   accept;
  logic [PIPE_STAGES-1:0] stage_valid;
  logic [PIPE_STAGES-1:0] stage_ready;
  logic [PIPE_STAGES-1:0] up_valid;
  logic [NO_OF_GATES-1:0] stage_data [PIPE_STAGES];
  logic [NO_OF_GATES-1:0] up_data    [PIPE_STAGES];

  // A stage can load when it, or any stage downstream of it, has a hole, or
  // the sink is taking the last stage this cycle.
  always_comb begin
    logic hole;
    hole        = out_ready;
    stage_ready = '0;
    for (int j = LAST; j >= 0; j--) begin
      hole           = hole | ~stage_valid[j];
      stage_ready[j] = hole;
    end
  end

  assign in_ready = started & stage_ready[0];
  assign accept   = in_valid & in_ready;

  always_comb begin
    up_valid    = '0;
    up_valid[0] = accept;
    up_data[0]  = reduced;
    for (int j = 1; j < PIPE_STAGES; j++) begin
      up_valid[j] = stage_valid[j-1];
      up_data[j]  = stage_data[j-1];
    end
  end

  always_ff @(posedge clock0 or negedge reset0_n) begin
    if (!reset0_n) started <= 1'b0;
    else           started <= 1'b1;
  end

  always_ff @(posedge clock0 or negedge reset0_n) begin
    if (!reset0_n) begin
      stage_valid <= '0;
      // NOTE: the data registers are reset too, so out1 reads 0 during reset
      // rather than whatever the last beat left behind.
      for (int j = 0; j < PIPE_STAGES; j++) stage_data[j] <= '0;
    end else begin
      for (int j = 0; j < PIPE_STAGES; j++) begin
        if (stage_ready[j]) begin
          stage_valid[j] <= up_valid[j];
          if (up_valid[j]) stage_data[j] <= up_data[j];
        end
      end
    end
  end

  assign out1      = stage_data[LAST];
  assign out_valid = stage_valid[LAST];

  always_ff @(posedge clock0 or negedge reset0_n) begin
    if (!reset0_n)
      out_count <= '0;
    else if (out_valid && out_ready && (out_count != '1))
      out_count <= out_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_logic_reduce_pipe.sv
// Bench for logic_reduce_pipe: three configurations share one input stream and
// are checked every cycle against a queue-of-beats model of the pipeline.
module tb_logic_reduce_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_data;
  logic [1:0]  mode;
  logic        in_valid;
  logic [2:0]  out_ready;

  logic        rdy0, rdy1, rdy2;
  logic        vld0, vld1, vld2;
  logic [3:0]  o0, o1;
  logic [1:0]  o2;
  logic [3:0]  c0;
  logic [15:0] c1;
  logic [4:0]  c2;

  always #5 clk = ~clk;

  logic_reduce_pipe #(.NO_OF_GATES(4), .NO_OF_INPUTS(4), .PIPE_STAGES(1), .CNT_W(4)) dut0 (
    .clock0(clk), .reset0_n(rst_n), .in_data(in_data), .mode(mode), .in_valid(in_valid),
    .in_ready(rdy0), .out1(o0), .out_valid(vld0), .out_ready(out_ready[0]), .out_count(c0));

  logic_reduce_pipe #(.NO_OF_GATES(4), .NO_OF_INPUTS(4), .PIPE_STAGES(3), .CNT_W(16)) dut1 (
    .clock0(clk), .reset0_n(rst_n), .in_data(in_data), .mode(mode), .in_valid(in_valid),
    .in_ready(rdy1), .out1(o1), .out_valid(vld1), .out_ready(out_ready[1]), .out_count(c1));

  logic_reduce_pipe #(.NO_OF_GATES(2), .NO_OF_INPUTS(8), .PIPE_STAGES(2), .CNT_W(5)) dut2 (
    .clock0(clk), .reset0_n(rst_n), .in_data(in_data), .mode(mode), .in_valid(in_valid),
    .in_ready(rdy2), .out1(o2), .out_valid(vld2), .out_ready(out_ready[2]), .out_count(c2));

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: beats in flight per DUT, oldest first, with their stage index.
  logic [3:0] m_data [3][4];
  int         m_pos  [3][4];
  int         m_size [3];
  int         m_count[3];
  bit         started;

  logic [15:0] sweep_pack = 16'hE2B1;  // dut0: AND 0001, OR 1011, XOR 0010, NAND 1110
  logic [7:0]  mc_pack    = 8'hEC;     // dut2: AND 00, OR 11, XOR 10, NAND 11

  function automatic int n_st(int k);
    case (k) 0: return 1; 1: return 3; default: return 2; endcase
  endfunction
  function automatic int n_gates(int k); return (k == 2) ? 2 : 4; endfunction
  function automatic int n_in(int k);    return (k == 2) ? 8 : 4; endfunction
  function automatic int cap(int k);
    case (k) 0: return 15; 1: return 65535; default: return 31; endcase
  endfunction

  function automatic logic [31:0] dut_rdy(int k);
    case (k) 0: return 32'(rdy0); 1: return 32'(rdy1); default: return 32'(rdy2); endcase
  endfunction
  function automatic logic [31:0] dut_vld(int k);
    case (k) 0: return 32'(vld0); 1: return 32'(vld1); default: return 32'(vld2); endcase
  endfunction
  function automatic logic [31:0] dut_out(int k);
    case (k) 0: return 32'(o0); 1: return 32'(o1); default: return 32'(o2); endcase
  endfunction
  function automatic logic [31:0] dut_cnt(int k);
    case (k) 0: return 32'(c0); 1: return 32'(c1); default: return 32'(c2); endcase
  endfunction

  // Reduction from the function definitions: count the ones in each lane.
  function automatic logic [3:0] ref_reduce(int k, logic [15:0] d, logic [1:0] m);
    logic [3:0] r;
    int g, n, ones;
    r = '0;
    g = n_gates(k);
    n = n_in(k);
    for (int i = 0; i < g; i++) begin
      ones = 0;
      for (int j = 0; j < n; j++) ones += int'(d[j*g + i]);
      case (m)
        2'd0:    r[i] = (ones == n);
        2'd1:    r[i] = (ones > 0);
        2'd2:    r[i] = (ones % 2 == 1);
        default: r[i] = (ones != n);
      endcase
    end
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_size[k]  = 0;
      m_count[k] = 0;
    end
    started = 1'b0;
  endtask

  function automatic bit exp_ready(int k);
    return started && ((m_size[k] < n_st(k)) || out_ready[k]);
  endfunction
  function automatic bit exp_valid(int k);
    return (m_size[k] > 0) && (m_pos[k][0] == n_st(k) - 1);
  endfunction

  task automatic compare();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("dut%0d_in_ready", k),  dut_rdy(k), 32'(exp_ready(k)));
      check($sformatf("dut%0d_out_valid", k), dut_vld(k), 32'(exp_valid(k)));
      check($sformatf("dut%0d_out_count", k), dut_cnt(k), 32'(m_count[k]));
      if (exp_valid(k))
        check($sformatf("dut%0d_out1", k), dut_out(k), 32'(m_data[k][0]));
      if (!rst_n)
        check($sformatf("dut%0d_out1_reset", k), dut_out(k), 32'd0);
    end
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_step();
    bit acc, del;
    int lim;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 3; k++) begin
      acc = in_valid && exp_ready(k);
      del = exp_valid(k) && out_ready[k];
      if (del) begin
        if (m_count[k] < cap(k)) m_count[k]++;
        for (int q = 1; q < m_size[k]; q++) begin
          m_data[k][q-1] = m_data[k][q];
          m_pos[k][q-1]  = m_pos[k][q];
        end
        m_size[k]--;
      end
      for (int q = 0; q < m_size[k]; q++) begin
        lim = (q == 0) ? n_st(k) - 1 : m_pos[k][q-1] - 1;
        m_pos[k][q] = (m_pos[k][q] + 1 < lim) ? m_pos[k][q] + 1 : lim;
      end
      if (acc) begin
        m_data[k][m_size[k]] = ref_reduce(k, in_data, mode);
        m_pos[k][m_size[k]]  = 0;
        m_size[k]++;
      end
    end
    started = 1'b1;
  endtask

  // Inputs are applied by the caller just after a falling edge.
  task automatic cycle();
    #1;
    compare();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    model_reset();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = 16'h0;
    mode      = 2'b00;
    in_valid  = 1'b1;
    out_ready = 3'b111;
    model_reset();
    @(negedge clk);

    // Reset held with a valid beat offered: nothing may be accepted.
    for (int i = 0; i < 3; i++) begin
      in_data = 16'($urandom);
      cycle();
    end
    check("reset_in_ready", 32'(rdy1), 32'd0);
    check("reset_out_count", 32'(c0), 32'd0);

    rst_n    = 1'b1;
    in_valid = 1'b0;
    cycle();
    check("release_in_ready", 32'(rdy0), 32'd1);
    for (int i = 0; i < 2; i++) cycle();
    check("idle_out_valid", 32'(vld0), 32'd0);

    // Function sweep, one beat per mode with the fixed operand pattern.
    in_data  = 16'h13BB;
    in_valid = 1'b1;
    for (int m = 0; m < 4; m++) begin
      mode = 2'(m);
      cycle();
      check($sformatf("sweep_dut0_mode%0d", m), 32'(o0), 32'(sweep_pack[m*4 +: 4]));
      check($sformatf("sweep_dut0_valid%0d", m), 32'(vld0), 32'd1);
      if (m >= 1)
        check($sformatf("modechg_dut2_beat%0d", m-1), 32'(o2), 32'(mc_pack[(m-1)*2 +: 2]));
    end

    // More beats in flight, then a reset in mid-stream.
    for (int i = 0; i < 2; i++) begin
      in_data = 16'($urandom);
      mode    = 2'($urandom);
      cycle();
    end
    assert_reset();
    cycle();
    cycle();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    check("post_reset_no_stale_dut1", 32'(vld1), 32'd0);
    check("post_reset_no_stale_dut2", 32'(vld2), 32'd0);

    // Latency and throughput: ten back-to-back beats.
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 16'($urandom);
      mode    = 2'($urandom);
      cycle();
      if (i == 1) check("latency_dut1_edge2", 32'(vld1), 32'd0);
      if (i == 2) check("latency_dut1_edge3", 32'(vld1), 32'd1);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    check("throughput_dut1_count", 32'(c1), 32'd10);

    // Backpressure: sink stalled for six cycles with beats offered.
    out_ready = 3'b000;
    in_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = 16'($urandom);
      mode    = 2'($urandom);
      cycle();
      if (i == 1) check("bp_dut1_ready_2acc", 32'(rdy1), 32'd1);
      if (i == 2) check("bp_dut1_ready_full", 32'(rdy1), 32'd0);
    end
    out_ready = 3'b111;
    #1;
    check("bp_dut1_resume_ready", 32'(rdy1), 32'd1);
    for (int i = 0; i < 3; i++) begin
      in_data = 16'($urandom);
      cycle();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    // Randomised traffic with sink stalls and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if (!rst_n)                           rst_n = 1'b1;
      else if ($urandom_range(0, 199) == 0) assert_reset();
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 16'($urandom);
      mode      = 2'($urandom);
      out_ready = {($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6)};
      cycle();
    end

    // Saturation: 20 deliveries into a 4-bit counter.
    assert_reset();
    in_valid  = 1'b0;
    out_ready = 3'b111;
    cycle();
    rst_n = 1'b1;
    cycle();
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 16'($urandom);
      mode    = 2'($urandom);
      cycle();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    check("sat_dut0_count", 32'(c0), 32'd15);
    check("sat_dut1_count", 32'(c1), 32'd20);
    check("sat_dut2_count", 32'(c2), 32'd20);
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) cycle();
    check("sat_dut0_hold", 32'(c0), 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
